// File: rtl/mc_control.sv
// Multi-cycle datapath controller: fetch/decode/execute/mem/writeback sequencing.
// Define MC_ADDI_EN to add the addi instruction (states ADDI_EX/ADDI_WB).
module mc_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dest,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WB   = 4'd5,
      MEM_WR   = 4'd6,
      EXEC     = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      ADDI_EX  = 4'd11,
      ADDI_WB  = 4'd12
   } stateT;

   localparam logic [5:0] opRType = 6'b000000;
   localparam logic [5:0] opLw    = 6'b100011;
   localparam logic [5:0] opSw    = 6'b101011;
   localparam logic [5:0] opBeq   = 6'b000100;
   localparam logic [5:0] opJ     = 6'b000010;
   localparam logic [5:0] opAddi  = 6'b001000;

   stateT curState;
   stateT nextState;
   logic  retireNow;
   logic  addiOk;
   logic  unusedZero;

   // zero only qualifies pc_write_cond in the datapath
   assign unusedZero = zero;
   assign state = curState;

`ifdef MC_ADDI_EN
   assign addiOk = (opcode == opAddi);
`else
   assign addiOk = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState <= IDLE;
         retired  <= '0;
      end else begin
         curState <= nextState;
         if (retireNow)
            retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      nextState     = IDLE;
      retireNow     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dest      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      case (curState)
         IDLE: nextState = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            nextState = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'b10;
            case (opcode)
               opRType:    nextState = EXEC;
               opLw, opSw: nextState = MEM_ADDR;
               opBeq:      nextState = BRANCH;
               opJ:        nextState = JUMP;
               default: begin
                  if (addiOk) begin
                     nextState = ADDI_EX;
                  end else begin
                     illegal_op = 1'b1;
                     nextState  = FETCH;
                  end
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nextState = (opcode == opSw) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read  = 1'b1;
            iord      = 1'b1;
            nextState = mem_ready ? MEM_WB : MEM_RD;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retireNow  = 1'b1;
            nextState  = FETCH;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retireNow = mem_ready;
            nextState = mem_ready ? FETCH : MEM_WR;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nextState = ALU_WB;
         end
         ALU_WB: begin
            reg_write = 1'b1;
            reg_dest  = 1'b1;
            retireNow = 1'b1;
            nextState = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retireNow     = 1'b1;
            nextState     = FETCH;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retireNow = 1'b1;
            nextState = FETCH;
         end
`ifdef MC_ADDI_EN
         ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nextState = ADDI_WB;
         end
         ADDI_WB: begin
            reg_write = 1'b1;
            retireNow = 1'b1;
            nextState = FETCH;
         end
`endif
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction stream against a per-instruction sequence model.
// Checks state, control word and retired count every cycle.
module tb_mc_control;

   localparam logic [5:0] opR    = 6'b000000;
   localparam logic [5:0] opLw   = 6'b100011;
   localparam logic [5:0] opSw   = 6'b101011;
   localparam logic [5:0] opBeq  = 6'b000100;
   localparam logic [5:0] opJ    = 6'b000010;
   localparam logic [5:0] opAddi = 6'b001000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;

   logic        pc_write, pc_write_cond, iord, mem_read, mem_write;
   logic        ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic        illegal_op;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        sPw, sPwc, sIord, sMr, sMw, sIrw, sM2r, sRd, sRw, sSa;
   logic [1:0]  sSb, sAo, sPs;
   logic        sIll;
   logic [3:0]  sState;
   logic [2:0]  sRetired;

   logic [16:0] ctl;
   logic [31:0] expRetired = '0;
   logic [5:0]  curOp = '0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mc_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg),
      .reg_dest(reg_dest), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_source(pc_source),
      .illegal_op(illegal_op), .state(state), .retired(retired)
   );

   mc_control #(.CNT_W(3)) dutSmall (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(sPw),
      .pc_write_cond(sPwc), .iord(sIord),
      .mem_read(sMr), .mem_write(sMw),
      .ir_write(sIrw), .mem_to_reg(sM2r),
      .reg_dest(sRd), .reg_write(sRw),
      .alu_src_a(sSa), .alu_src_b(sSb),
      .alu_op(sAo), .pc_source(sPs),
      .illegal_op(sIll), .state(sState), .retired(sRetired)
   );

   assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_source, illegal_op};

   function automatic bit legal(input logic [5:0] op);
      bit ok;
      ok = (op == opR) || (op == opLw) || (op == opSw) ||
           (op == opBeq) || (op == opJ);
`ifdef MC_ADDI_EN
      ok = ok || (op == opAddi);
`endif
      return ok;
   endfunction

   // Expected control word for a state, straight from the state table
   function automatic logic [16:0] expCtl(input int st, input logic rdy,
                                          input logic [5:0] op);
      logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
      logic [1:0] sb, ao, ps;
      {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
      sb = 2'd0;
      ao = 2'd0;
      ps = 2'd0;
      case (st)
         1:  begin mr = 1; sb = 2'd1; irw = rdy; pw = rdy; end
         2:  begin sb = 2'd2; ill = !legal(op); end
         3:  begin sa = 1; sb = 2'd2; end
         4:  begin mr = 1; io = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mw = 1; io = 1; end
         7:  begin sa = 1; ao = 2'd2; end
         8:  begin rw = 1; rd = 1; end
         9:  begin sa = 1; ao = 2'd1; pwc = 1; ps = 2'd1; end
         10: begin pw = 1; ps = 2'd2; end
         11: begin sa = 1; sb = 2'd2; end
         12: begin rw = 1; end
         default: ;
      endcase
      return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
   endfunction

   task automatic check(input int st);
      logic [16:0] e;
      e = expCtl(st, mem_ready, curOp);
      checks++;
      assert (state === 4'(st)) else begin
         failures++;
         $error("FAIL state obs=%0d exp=%0d", state, st);
      end
      checks++;
      assert (ctl === e) else begin
         failures++;
         $error("FAIL ctl st=%0d obs=%05h exp=%05h", st, ctl, e);
      end
      checks++;
      assert (retired === expRetired) else begin
         failures++;
         $error("FAIL retired obs=%0d exp=%0d", retired, expRetired);
      end
      checks++;
      assert (sRetired === expRetired[2:0]) else begin
         failures++;
         $error("FAIL retired_w3 obs=%0d exp=%0d", sRetired, expRetired[2:0]);
      end
   endtask

   task automatic cyc(input int st, input logic rdy, input bit fin);
      @(negedge clk);
      mem_ready = rdy;
      zero = 1'($urandom);
      opcode = curOp;
      #1;
      check(st);
      if (fin)
         expRetired = expRetired + 32'd1;
   endtask

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic holdReset(input int n);
      rst = 1'b1;
      expRetired = '0;
      for (int i = 0; i < n; i++)
         cyc(0, 1'b1, 1'b0);
      rst = 1'b0;
   endtask

   // One instruction: fw fetch waits, mw memory waits
   task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
      curOp = 6'($urandom);
      for (int i = 0; i < fw; i++)
         cyc(1, 1'b0, 1'b0);
      cyc(1, 1'b1, 1'b0);
      curOp = op;
      cyc(2, rb(), 1'b0);
      if (op == opR) begin
         cyc(7, rb(), 1'b0);
         cyc(8, rb(), 1'b1);
      end else if (op == opLw) begin
         cyc(3, rb(), 1'b0);
         for (int i = 0; i < mw; i++)
            cyc(4, 1'b0, 1'b0);
         cyc(4, 1'b1, 1'b0);
         cyc(5, rb(), 1'b1);
      end else if (op == opSw) begin
         cyc(3, rb(), 1'b0);
         for (int i = 0; i < mw; i++)
            cyc(6, 1'b0, 1'b0);
         cyc(6, 1'b1, 1'b1);
      end else if (op == opBeq) begin
         cyc(9, rb(), 1'b1);
      end else if (op == opJ) begin
         cyc(10, rb(), 1'b1);
      end else if (legal(op)) begin
         cyc(11, rb(), 1'b0);
         cyc(12, rb(), 1'b1);
      end
   endtask

   task automatic randomInstr();
      logic [5:0] op;
      case ($urandom_range(6, 0))
         0: op = opR;
         1: op = opLw;
         2: op = opSw;
         3: op = opBeq;
         4: op = opJ;
         5: op = opAddi;
         default: op = 6'($urandom);
      endcase
      runInstr(op, $urandom_range(2, 0), $urandom_range(3, 0));
   endtask

   initial begin
      holdReset(3);
      runInstr(opR, 0, 0);
      runInstr(opLw, 0, 2);
      runInstr(opSw, 0, 0);
      runInstr(opBeq, 1, 0);
      runInstr(opBeq, 0, 0);
      runInstr(6'b111111, 0, 0);
      runInstr(opJ, 0, 0);
      runInstr(opAddi, 0, 0);
      for (int n = 0; n < 200; n++)
         randomInstr();

      // Abort a load while it waits on memory
      curOp = 6'($urandom);
      cyc(1, 1'b1, 1'b0);
      curOp = opLw;
      cyc(2, 1'b1, 1'b0);
      cyc(3, 1'b1, 1'b0);
      cyc(4, 1'b0, 1'b0);
      rst = 1'b1;
      expRetired = '0;
      #1;
      check(0);
      holdReset(2);
      for (int n = 0; n < 40; n++)
         randomInstr();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
